// File: rtl/noc_vc_input_buffer.sv
// Per-port NoC input buffer: NUM_VC circular flit FIFOs in one shared array, with per-VC
// status, one upstream credit per dequeued flit, and sticky protocol-error flags.
module noc_vc_input_buffer #(
  parameter int unsigned FLIT_W = 12,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NUM_VC = 2,
  parameter int unsigned VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    enq_valid,
  input  logic [VC_W-1:0]         enq_vc,
  input  logic [FLIT_W-1:0]       enq_data,
  input  logic                    deq_valid,
  input  logic [VC_W-1:0]         deq_vc,
  output logic [FLIT_W-1:0]       deq_data,
  output logic [NUM_VC-1:0]       vc_not_empty,
  output logic [NUM_VC-1:0]       vc_not_full,
  output logic [NUM_VC*CNT_W-1:0] vc_count,
  output logic                    credit_valid,
  output logic [VC_W-1:0]         credit_vc,
  output logic                    err_overflow,
  output logic                    err_underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned AW    = $clog2(NUM_VC * DEPTH);

  logic [FLIT_W-1:0] mem_q [NUM_VC*DEPTH];

  logic [PTR_W-1:0]  head_q  [NUM_VC];
  logic [PTR_W-1:0]  head_d  [NUM_VC];
  logic [PTR_W-1:0]  tail_q  [NUM_VC];
  logic [PTR_W-1:0]  tail_d  [NUM_VC];
  logic [CNT_W-1:0]  count_q [NUM_VC];
  logic [CNT_W-1:0]  count_d [NUM_VC];
  logic [NUM_VC-1:0] not_empty_q, not_empty_d;
  logic [NUM_VC-1:0] not_full_q, not_full_d;
  logic [NUM_VC-1:0] enq_hit, deq_hit;

  logic              credit_valid_q;
  logic [VC_W-1:0]   credit_vc_q;
  logic              err_ovf_q, err_unf_q;

  logic              enq_in_range, deq_in_range;
  logic [VC_W-1:0]   enq_idx, deq_idx;
  logic              enq_ok, deq_ok;
  logic [AW-1:0]     wr_addr, rd_addr;

  // Accept decisions use registered status only, so there is no enqueue/dequeue bypass.
  always_comb begin
    enq_in_range = 32'(enq_vc) < NUM_VC;
    deq_in_range = 32'(deq_vc) < NUM_VC;
    enq_idx      = enq_in_range ? enq_vc : '0;
    deq_idx      = deq_in_range ? deq_vc : '0;
    enq_ok       = enq_valid && enq_in_range && not_full_q[enq_idx];
    deq_ok       = deq_valid && deq_in_range && not_empty_q[deq_idx];
    wr_addr      = AW'(enq_idx) * AW'(DEPTH) + AW'(tail_q[enq_idx]);
    rd_addr      = AW'(deq_idx) * AW'(DEPTH) + AW'(head_q[deq_idx]);
  end

  always_comb begin
    enq_hit = '0;
    deq_hit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      enq_hit[v] = enq_ok && (enq_idx == VC_W'(v));
      deq_hit[v] = deq_ok && (deq_idx == VC_W'(v));
      head_d[v]  = deq_hit[v] ? head_q[v] + PTR_W'(1) : head_q[v];
      tail_d[v]  = enq_hit[v] ? tail_q[v] + PTR_W'(1) : tail_q[v];
      count_d[v] = count_q[v];
      if (enq_hit[v] && !deq_hit[v]) begin
        count_d[v] = count_q[v] + CNT_W'(1);
      end else if (!enq_hit[v] && deq_hit[v]) begin
        count_d[v] = count_q[v] - CNT_W'(1);
      end
      not_empty_d[v] = count_d[v] != '0;
      not_full_d[v]  = count_d[v] != CNT_W'(DEPTH);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int v = 0; v < NUM_VC; v++) begin
        head_q[v]  <= '0;
        tail_q[v]  <= '0;
        count_q[v] <= '0;
      end
      not_empty_q    <= '0;
      not_full_q     <= '1;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      err_ovf_q      <= 1'b0;
      err_unf_q      <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      not_empty_q    <= not_empty_d;
      not_full_q     <= not_full_d;
      credit_valid_q <= deq_ok;
      if (deq_ok) begin
        credit_vc_q <= deq_idx;
      end
      if (enq_valid && !enq_ok) begin
        err_ovf_q <= 1'b1;
      end
      if (deq_valid && !deq_ok) begin
        err_unf_q <= 1'b1;
      end
    end
  end

  // Flit storage is deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (RST_N && enq_ok) begin
      mem_q[wr_addr] <= enq_data;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (RST_N && enq_valid && !enq_ok) begin
      $display("noc_vc_input_buffer: overflow, flit dropped on vc %0d", enq_vc);
    end
    if (RST_N && deq_valid && !deq_ok) begin
      $display("noc_vc_input_buffer: underflow, dequeue ignored on vc %0d", deq_vc);
    end
  end
`endif

  always_comb begin
    deq_data = mem_q[rd_addr];
    vc_count = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      vc_count[v*CNT_W +: CNT_W] = count_q[v];
    end
  end

  assign vc_not_empty  = not_empty_q;
  assign vc_not_full   = not_full_q;
  assign credit_valid  = credit_valid_q;
  assign credit_vc     = credit_vc_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Scoreboard bench for noc_vc_input_buffer: a queue-per-VC model predicts every cycle's
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_noc_vc_input_buffer;

  localparam int unsigned FLIT_W = 12;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned NUM_VC = 2;
  localparam int unsigned VC_W   = 1;
  localparam int unsigned CNT_W  = 4;

  logic                    CLK = 1'b0;
  logic                    RST_N;
  logic                    enq_valid;
  logic [VC_W-1:0]         enq_vc;
  logic [FLIT_W-1:0]       enq_data;
  logic                    deq_valid;
  logic [VC_W-1:0]         deq_vc;
  logic [FLIT_W-1:0]       deq_data;
  logic [NUM_VC-1:0]       vc_not_empty;
  logic [NUM_VC-1:0]       vc_not_full;
  logic [NUM_VC*CNT_W-1:0] vc_count;
  logic                    credit_valid;
  logic [VC_W-1:0]         credit_vc;
  logic                    err_overflow;
  logic                    err_underflow;

  noc_vc_input_buffer #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH),
    .NUM_VC (NUM_VC),
    .VC_W   (VC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .enq_valid     (enq_valid),
    .enq_vc        (enq_vc),
    .enq_data      (enq_data),
    .deq_valid     (deq_valid),
    .deq_vc        (deq_vc),
    .deq_data      (deq_data),
    .vc_not_empty  (vc_not_empty),
    .vc_not_full   (vc_not_full),
    .vc_count      (vc_count),
    .credit_valid  (credit_valid),
    .credit_vc     (credit_vc),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic                    deq_chk;
    logic [FLIT_W-1:0]       deq_data;
    logic [NUM_VC-1:0]       ne;
    logic [NUM_VC-1:0]       nf;
    logic [NUM_VC*CNT_W-1:0] cnt;
    logic                    cv;
    logic [VC_W-1:0]         cvc;
    logic                    eo;
    logic                    eu;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: plain queues plus the visible registered flags.
  logic [FLIT_W-1:0] mq[NUM_VC][$];
  logic              m_cv, m_eo, m_eu;
  logic [VC_W-1:0]   m_cvc;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.deq_chk) chk("deq_data", 32'(deq_data), 32'(e.deq_data));
      chk("vc_count", 32'(vc_count), 32'(e.cnt));
      chk("vc_not_empty", 32'(vc_not_empty), 32'(e.ne));
      chk("vc_not_full", 32'(vc_not_full), 32'(e.nf));
      chk("credit_valid", 32'(credit_valid), 32'(e.cv));
      if (e.cv) chk("credit_vc", 32'(credit_vc), 32'(e.cvc));
      chk("err_overflow", 32'(err_overflow), 32'(e.eo));
      chk("err_underflow", 32'(err_underflow), 32'(e.eu));
    end
  end

  function automatic void model_reset();
    for (int v = 0; v < NUM_VC; v++) mq[v].delete();
    m_cv  = 1'b0;
    m_cvc = '0;
    m_eo  = 1'b0;
    m_eu  = 1'b0;
  endfunction

  // One clock of stimulus: drive, record the outputs this cycle must show, then advance the model.
  task automatic drive(input logic rst, input logic ev, input logic [VC_W-1:0] evc,
                       input logic [FLIT_W-1:0] ed, input logic dv,
                       input logic [VC_W-1:0] dvc);
    exp_t e;
    logic enq_ok, deq_ok;
    @(posedge CLK);
    #1;
    RST_N     = rst;
    enq_valid = ev;
    enq_vc    = evc;
    enq_data  = ed;
    deq_valid = dv;
    deq_vc    = dvc;
    e.deq_chk  = dv && (mq[dvc].size() > 0);
    e.deq_data = e.deq_chk ? mq[dvc][0] : '0;
    e.cnt = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      e.cnt[v*CNT_W +: CNT_W] = CNT_W'(mq[v].size());
      e.ne[v] = mq[v].size() != 0;
      e.nf[v] = mq[v].size() != DEPTH;
    end
    e.cv  = m_cv;
    e.cvc = m_cvc;
    e.eo  = m_eo;
    e.eu  = m_eu;
    exp_q.push_back(e);
    if (!rst) begin
      model_reset();
    end else begin
      enq_ok = ev && (mq[evc].size() < DEPTH);
      deq_ok = dv && (mq[dvc].size() > 0);
      if (deq_ok) void'(mq[dvc].pop_front());
      if (enq_ok) mq[evc].push_back(ed);
      m_cv = deq_ok;
      if (deq_ok) m_cvc = dvc;
      if (ev && !enq_ok) m_eo = 1'b1;
      if (dv && !deq_ok) m_eu = 1'b1;
    end
  endtask

  task automatic enq(input logic [VC_W-1:0] vc, input logic [FLIT_W-1:0] d);
    drive(1'b1, 1'b1, vc, d, 1'b0, '0);
  endtask

  task automatic deq(input logic [VC_W-1:0] vc);
    drive(1'b1, 1'b0, '0, '0, 1'b1, vc);
  endtask

  task automatic drain(input logic [VC_W-1:0] vc);
    while (mq[vc].size() > 0) deq(vc);
  endtask

  initial begin
    RST_N     = 1'b0;
    enq_valid = 1'b0;
    enq_vc    = '0;
    enq_data  = '0;
    deq_valid = 1'b0;
    deq_vc    = '0;
    model_reset();
    repeat (2) @(posedge CLK);

    // Fill VC0, then overflow it, then drain in order with credits.
    for (int i = 1; i <= 8; i++) enq(1'b0, FLIT_W'(i));
    enq(1'b0, 12'hFFF);
    for (int i = 0; i < 8; i++) deq(1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);

    // Pointer wrap-around on VC1.
    for (int i = 0; i < 5; i++) enq(1'b1, FLIT_W'($urandom));
    for (int i = 0; i < 5; i++) deq(1'b1);
    for (int i = 0; i < 6; i++) enq(1'b1, FLIT_W'(12'h100 + i));
    drain(1'b1);

    // Same-VC and cross-VC simultaneous enqueue/dequeue.
    for (int i = 1; i <= 3; i++) enq(1'b1, FLIT_W'(12'h0A0 + i));
    drive(1'b1, 1'b1, 1'b1, 12'h0AA, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 12'h0BB, 1'b1, 1'b1);
    drain(1'b1);
    drain(1'b0);

    // Underflow on empty VC0 while enqueueing to it.
    drive(1'b1, 1'b1, 1'b0, 12'h055, 1'b1, 1'b0);
    deq(1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);

    // Reset mid-operation cancels the pending credit and all state.
    for (int i = 0; i < 4; i++) enq(1'b0, FLIT_W'(12'h300 + i));
    deq(1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99) != 0), ($urandom_range(2) != 0), VC_W'($urandom),
            FLIT_W'($urandom), ($urandom_range(2) != 0), VC_W'($urandom));
    end
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);

    @(negedge CLK);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
